// File: rtl/iq_pkg.sv
// ----------------------------------------------------------------------------
// iq_pkg
// Shared definitions for the issue-queue dispatch controller:
//   - iq_state_e : controller FSM state encoding (RUN / STALL / FLUSH)
//   - DISP_W     : dispatch group width (lanes per cycle)
// ----------------------------------------------------------------------------
package iq_pkg;

    localparam int DISP_W = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } iq_state_e;

endpackage : iq_pkg

// File: rtl/iq_dispatch_ctrl_popcount4.sv
// ----------------------------------------------------------------------------
// popcount4
// Purely combinational population count of a 4-bit dispatch valid mask.
// Ports:
//   i_mask  in  4  lane valid mask
//   o_cnt   out 3  number of set bits (0..4)
// ----------------------------------------------------------------------------
module popcount4 (
    input  logic [3:0] i_mask,
    output logic [2:0] o_cnt
);

    always_comb begin
        o_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            o_cnt = o_cnt + {2'b00, i_mask[i]};
        end
    end

endmodule : popcount4

// File: rtl/iq_dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// iq_dispatch_ctrl
// Occupancy / flow controller for a 4-in/1-out compacting issue queue.
// Accepts whole dispatch groups of up to 4 instructions, drives the queue
// write/shift enable, tracks live entries from issue and branch-kill events,
// and holds the queue disabled for FLUSH_CYC cycles after a pipeline flush.
//
// Parameters:
//   SIZE       issue-queue entries (>= 4)
//   FLUSH_CYC  cycles the queue is held disabled after a flush (>= 1)
//   CW         count width, $clog2(SIZE+1) (derived)
//
// Ports:
//   i_clk         in   1   clock, rising edge
//   i_rst_n       in   1   asynchronous active-low reset
//   i_disp_valid  in   4   dispatch lane valids, contiguous from bit 0
//   o_disp_ready  out  1   group accepted when valid!=0 && ready
//   o_en          out  1   issue-queue shift/write enable
//   i_issue       in   1   queue granted one entry this cycle
//   i_kill_cnt    in   CW  entries squashed by branch kill this cycle
//   i_flush       in   1   full pipeline flush
//   o_count       out  CW  live entries
//   o_full        out  1   o_count > SIZE-4
//   o_empty       out  1   o_count == 0
//   o_stall_cyc   out  32  (IQ_STATS_EN only) saturating count of cycles in
//                          which dispatch was valid but not ready
//
// Build option: define IQ_STATS_EN to add the o_stall_cyc counter/port.
// ----------------------------------------------------------------------------
module iq_dispatch_ctrl
    import iq_pkg::*;
#(
    parameter  int SIZE      = 32,
    parameter  int FLUSH_CYC = 2,
    localparam int CW        = $clog2(SIZE + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DISP_W-1:0] i_disp_valid,
    output logic              o_disp_ready,
    output logic              o_en,
    input  logic              i_issue,
    input  logic [CW-1:0]     i_kill_cnt,
    input  logic              i_flush,
    output logic [CW-1:0]     o_count,
    output logic              o_full,
`ifdef IQ_STATS_EN
    output logic [31:0]       o_stall_cyc,
`endif
    output logic              o_empty
);

    localparam int          TW        = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(FLUSH_CYC - 1);
    // Highest occupancy at which a full 4-wide group still fits.
    localparam logic [CW:0] FIT_LIM   = (CW + 1)'(SIZE - DISP_W);
    localparam logic [CW:0] SIZE_W    = (CW + 1)'(SIZE);

    // Registered state
    iq_state_e     r_state;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_timer;
    logic          r_full;
    logic          r_empty;

    // Combinational
    iq_state_e     w_state_next;
    logic [TW-1:0] w_timer_next;
    logic [2:0]    w_popcnt;
    logic [CW:0]   w_room;
    logic          w_ready;
    logic          w_accept;
    logic [CW:0]   w_add;
    logic [CW:0]   w_sub;
    logic [CW:0]   w_diff;
    logic          w_underflow;
    logic [CW-1:0] w_count_next;
    logic          w_en;

    popcount4 u_popcount4 (
        .i_mask (i_disp_valid),
        .o_cnt  (w_popcnt)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_count <= '0;
            r_timer <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_timer <= w_timer_next;
            r_full  <= ({1'b0, w_count_next} > FIT_LIM);
            r_empty <= (w_count_next == '0);
        end
    end

    // ------------------------------------------------------------------
    // Next-state, occupancy arithmetic and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;

        // Ready depends only on registered state so it never loops back
        // through the dispatch stage in the same cycle.
        w_room   = SIZE_W - {1'b0, r_count};
        w_ready  = (r_state != FLUSH) && (w_room >= (CW + 1)'(DISP_W));
        // Flush wins over everything: a group presented alongside it is dropped.
        w_accept = (i_disp_valid != '0) && w_ready && !i_flush;

        // Arithmetic is one bit wider than the count so underflow is visible.
        w_add       = {1'b0, r_count} + (w_accept ? (CW + 1)'(w_popcnt) : '0);
        w_sub       = (CW + 1)'(i_issue) + {1'b0, i_kill_cnt};
        w_underflow = (w_sub > w_add);
        w_diff      = w_add - w_sub;

        if (i_flush || w_underflow) begin
            w_count_next = '0;
        end else begin
            w_count_next = w_diff[CW-1:0];
        end

        // The queue is frozen for the whole flush window, including the
        // cycle the flush itself is signalled.
        w_en = (r_state != FLUSH) && !i_flush &&
               (w_accept || i_issue || (i_kill_cnt != '0));

        case (r_state)
            RUN, STALL: begin
                if (i_flush) begin
                    w_state_next = FLUSH;
                    w_timer_next = TMR_LOAD;
                end else if ({1'b0, w_count_next} > FIT_LIM) begin
                    w_state_next = STALL;
                end else begin
                    w_state_next = RUN;
                end
            end
            FLUSH: begin
                if (i_flush) begin
                    w_timer_next = TMR_LOAD;
                end else if (r_timer == '0) begin
                    w_state_next = RUN;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_next = RUN;
                w_timer_next = '0;
            end
        endcase
    end

    assign o_disp_ready = w_ready;
    assign o_en         = w_en;
    assign o_count      = r_count;
    assign o_full       = r_full;
    assign o_empty      = r_empty;

`ifdef IQ_STATS_EN
    logic [31:0] r_stall_cyc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cyc <= '0;
        end else if ((i_disp_valid != '0) && !w_ready && (r_stall_cyc != 32'hFFFF_FFFF)) begin
            r_stall_cyc <= r_stall_cyc + 32'd1;
        end
    end

    assign o_stall_cyc = r_stall_cyc;
`endif

`ifndef SYNTHESIS
    // Protocol sanity: lanes must fill from bit 0, and the count may not go
    // negative (an upstream accounting bug; the count is clamped to 0).
    always @(posedge i_clk) begin
        if (i_rst_n) begin
            if ((i_disp_valid & (i_disp_valid + 4'd1)) != 4'd0) begin
                $error("iq_dispatch_ctrl: non-contiguous i_disp_valid %b", i_disp_valid);
            end
            if (!i_flush && w_underflow) begin
                $error("iq_dispatch_ctrl: occupancy underflow (count %0d)", r_count);
            end
        end
    end
`endif

endmodule : iq_dispatch_ctrl

// File: tb/tb_iq_dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iq_dispatch_ctrl
// Directed self-checking bench for iq_dispatch_ctrl with SIZE=8, FLUSH_CYC=2.
// Observed vector layout: {ready, en, full, empty, count[3:0]}.
// ----------------------------------------------------------------------------
module tb_iq_dispatch_ctrl;
    import iq_pkg::*;

    localparam int SIZE = 8;
    localparam int FC   = 2;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    valid;
    logic          ready;
    logic          en;
    logic          issue;
    logic [CW-1:0] kill;
    logic          flush;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
`ifdef IQ_STATS_EN
    logic [31:0]   stall_cyc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] obs;
    assign obs = {ready, en, full, empty, count};

    iq_dispatch_ctrl #(.SIZE(SIZE), .FLUSH_CYC(FC)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_disp_valid (valid),
        .o_disp_ready (ready),
        .o_en         (en),
        .i_issue      (issue),
        .i_kill_cnt   (kill),
        .i_flush      (flush),
        .o_count      (count),
        .o_full       (full),
`ifdef IQ_STATS_EN
        .o_stall_cyc  (stall_cyc),
`endif
        .o_empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 4'b0; issue = 1'b0; kill = '0; flush = 1'b0;
        #12;
        n_checks++;
        if (obs !== 8'b1001_0000) begin n_fail++; $display("FAIL reset_outputs got %b want %b", obs, 8'b1001_0000); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (dut.r_state !== RUN) begin n_fail++; $display("FAIL reset_state got %0d want %0d", dut.r_state, RUN); end
        $display("reset: obs=%b", obs);
    endtask

    task automatic test_fill();
        valid = 4'b1111; #1;
        n_checks++;
        if (obs !== 8'b1101_0000) begin n_fail++; $display("FAIL fill_g1 got %b want %b", obs, 8'b1101_0000); end
        step();
        n_checks++;
        if (obs !== 8'b1100_0100) begin n_fail++; $display("FAIL fill_g2 got %b want %b", obs, 8'b1100_0100); end
        step();
        n_checks++;
        if (obs !== 8'b0010_1000) begin n_fail++; $display("FAIL fill_full got %b want %b", obs, 8'b0010_1000); end
        n_checks++;
        if (dut.r_state !== STALL) begin n_fail++; $display("FAIL fill_state got %0d want %0d", dut.r_state, STALL); end
        valid = 4'b0; #1;
        $display("fill: count=%0d full=%b", count, full);
    endtask

    task automatic test_drain();
        logic [3:0] exp_cnt;
        issue = 1'b1; #1;
        n_checks++;
        if (obs !== 8'b0110_1000) begin n_fail++; $display("FAIL drain_en got %b want %b", obs, 8'b0110_1000); end
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_cnt = 4'(8 - i);
            n_checks++;
            if (obs !== {4'b0110, exp_cnt}) begin n_fail++; $display("FAIL drain_%0d got %b want %b", i, obs, {4'b0110, exp_cnt}); end
        end
        step();
        issue = 1'b0; #1;
        n_checks++;
        if (obs !== 8'b1000_0100) begin n_fail++; $display("FAIL drain_ready got %b want %b", obs, 8'b1000_0100); end
        n_checks++;
        if (dut.r_state !== RUN) begin n_fail++; $display("FAIL drain_state got %0d want %0d", dut.r_state, RUN); end
        $display("drain: count=%0d ready=%b", count, ready);
    endtask

    task automatic test_simultaneous();
        valid = 4'b0011; issue = 1'b1; kill = 4'd2; #1;
        n_checks++;
        if (obs !== 8'b1100_0100) begin n_fail++; $display("FAIL simul_en got %b want %b", obs, 8'b1100_0100); end
        step();
        valid = 4'b0; issue = 1'b0; kill = '0; #1;
        n_checks++;
        if (obs !== 8'b1000_0011) begin n_fail++; $display("FAIL simul_count got %b want %b", obs, 8'b1000_0011); end
        $display("simultaneous: count=%0d", count);
    endtask

    task automatic test_flush();
        valid = 4'b0111; step();
        valid = 4'b0; #1;
        n_checks++;
        if (obs !== 8'b0010_0110) begin n_fail++; $display("FAIL flush_pre got %b want %b", obs, 8'b0010_0110); end
        valid = 4'b1111; flush = 1'b1; #1;
        n_checks++;
        if (obs !== 8'b0010_0110) begin n_fail++; $display("FAIL flush_cycle got %b want %b", obs, 8'b0010_0110); end
        step();
        flush = 1'b0; #1;
        for (int i = 1; i <= 2; i++) begin
            n_checks++;
            if (obs !== 8'b0001_0000 || dut.r_state !== FLUSH) begin
                n_fail++; $display("FAIL flush_hold_%0d got %b st=%0d want %b st=%0d", i, obs, dut.r_state, 8'b0001_0000, FLUSH);
            end
            if (i == 1) step();
        end
        step();
        n_checks++;
        if (obs !== 8'b1101_0000 || dut.r_state !== RUN) begin
            n_fail++; $display("FAIL flush_exit got %b st=%0d want %b st=%0d", obs, dut.r_state, 8'b1101_0000, RUN);
        end
        valid = 4'b0; #1;
        $display("flush: count=%0d state=%0d", count, dut.r_state);
    endtask

    task automatic test_flush_reload();
        flush = 1'b1; step();
        step();
        flush = 1'b0; #1;
        step();
        n_checks++;
        if (dut.r_state !== FLUSH) begin n_fail++; $display("FAIL reload_hold got %0d want %0d", dut.r_state, FLUSH); end
        step();
        n_checks++;
        if (dut.r_state !== RUN) begin n_fail++; $display("FAIL reload_exit got %0d want %0d", dut.r_state, RUN); end
        $display("flush_reload: state=%0d", dut.r_state);
    endtask

    task automatic test_async_reset();
        valid = 4'b1111; step(); step();
        valid = 4'b0; #1;
        n_checks++;
        if (obs !== 8'b0010_1000 || dut.r_state !== STALL) begin
            n_fail++; $display("FAIL areset_pre got %b st=%0d want %b st=%0d", obs, dut.r_state, 8'b0010_1000, STALL);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 8'b1001_0000 || dut.r_state !== RUN) begin
            n_fail++; $display("FAIL areset_now got %b st=%0d want %b st=%0d", obs, dut.r_state, 8'b1001_0000, RUN);
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (obs !== 8'b1001_0000) begin n_fail++; $display("FAIL areset_release got %b want %b", obs, 8'b1001_0000); end
        $display("async_reset: obs=%b", obs);
    endtask

`ifdef IQ_STATS_EN
    task automatic test_stats();
        n_checks++;
        if (stall_cyc !== 32'd0) begin n_fail++; $display("FAIL stats_reset got %0d want 0", stall_cyc); end
        valid = 4'b1111; step(); step();
        n_checks++;
        if (stall_cyc !== 32'd0) begin n_fail++; $display("FAIL stats_fill got %0d want 0", stall_cyc); end
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (stall_cyc !== 32'd5) begin n_fail++; $display("FAIL stats_stall got %0d want 5", stall_cyc); end
        valid = 4'b0; #1;
        $display("stats: stall_cyc=%0d", stall_cyc);
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_flush();
        test_flush_reload();
        test_async_reset();
`ifdef IQ_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_iq_dispatch_ctrl
